// File: rtl/mem_read_streamer.sv
// Read-side controller for a simple dual-port RAM. It issues credit-limited reads over a run of
// consecutive addresses and streams the returned words through a 4-entry show-ahead FIFO.
module mem_read_streamer #(
   parameter int  DATA_WIDTH   = 8,
   parameter int  DEPTH        = 16,
   parameter int  OUTPUT_DELAY = 1,
   localparam int AW           = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [AW-1:0]         base_addr,
   input  logic [AW:0]           length,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  reb,
   output logic [AW-1:0]         addrb,
   input  logic [DATA_WIDTH-1:0] dob,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
   localparam int            FIFO_SLOTS = 4;

   generate
      if ((OUTPUT_DELAY < 1) || (OUTPUT_DELAY > 3)) begin : g_bad_delay
         $fatal(1, "mem_read_streamer: OUTPUT_DELAY must be 1, 2 or 3");
      end
   endgenerate

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    r_done;
   logic                    w_done_set;

   logic [AW-1:0]           r_addr;
   logic [AW:0]             r_remaining;
   logic [OUTPUT_DELAY-1:0] r_vld_sr;

   logic [DATA_WIDTH-1:0]   r_fifo [FIFO_SLOTS];
   logic [1:0]              r_wr_ptr;
   logic [1:0]              r_rd_ptr;
   logic [2:0]              r_count;

   logic [2:0]              w_inflight;
   logic                    w_credit_ok;
   logic                    w_issue;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_abort;

   // Credit accounting: words still in the RAM pipeline plus words parked in the FIFO.
   always_comb begin
      // NOTE: a combinational accumulator uses blocking '=' so each iteration sees the
      // previous partial sum; clocked state below always uses '<='.
      w_inflight = 3'd0;
      for (int i = 0; i < OUTPUT_DELAY; i++) begin
         w_inflight = w_inflight + 3'(r_vld_sr[i]);
      end
      w_credit_ok = ({1'b0, w_inflight} + {1'b0, r_count}) < 4'(FIFO_SLOTS);
      w_push      = r_vld_sr[OUTPUT_DELAY-1];
      w_pop       = (r_count != 3'd0) && dout_ready;
      w_abort     = abort && (r_state != ST_IDLE);
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= w_done_set;
      end
   end

   // FSM: next state
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned,
      // which would otherwise infer a latch.
      w_next_state = r_state;
      w_done_set   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (length == '0) begin
                  w_done_set = 1'b1;
               end else begin
                  w_next_state = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if (w_issue && (r_remaining == (AW+1)'(1))) begin
               w_next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if ((w_inflight == 3'd0) && (r_count == 3'd1) && w_pop) begin
               w_next_state = ST_IDLE;
               w_done_set   = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_issue    = (r_state == ST_RUN) && (r_remaining != '0) && w_credit_ok;
      busy       = (r_state != ST_IDLE);
      done       = r_done;
      reb        = w_issue;
      addrb      = r_addr;
      dout       = r_fifo[r_rd_ptr];
      dout_valid = (r_count != 3'd0);
   end

   // Address counter and words-left counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_remaining <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_addr      <= base_addr;
         r_remaining <= length;
      end else if (w_abort) begin
         r_remaining <= '0;
      end else if (w_issue) begin
         r_addr      <= (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
         r_remaining <= r_remaining - (AW+1)'(1);
      end
   end

   // Valid shift register tracks the RAM read pipeline; abort drops stale returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_sr <= '0;
      end else if (w_abort) begin
         r_vld_sr <= '0;
      end else begin
         r_vld_sr[0] <= w_issue;
         for (int i = 1; i < OUTPUT_DELAY; i++) begin
            r_vld_sr[i] <= r_vld_sr[i-1];
         end
      end
   end

   // Show-ahead FIFO; the credit rule guarantees a free slot for every push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage is reset along with the pointers so dout reads 0 out of reset;
         // this keeps it in flops rather than a RAM macro, which is fine at 4 entries.
         for (int i = 0; i < FIFO_SLOTS; i++) begin
            r_fifo[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_abort) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= dob;
            r_wr_ptr         <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
